// File: rtl/pll_seq_ctrl.sv
// PLL bring-up and frequency-measurement sequencer: reset/power-down control, lock
// qualification and a fixed-width counter enable window, all in the reference domain.
//
// state     | meaning
// IDLE      | PLL held in reset, waiting for start
// PWRDN     | PLL powered down, window aborted
// RST_HOLD  | PLL reset asserted for RST_CYCLES
// WAIT_LOCK | reset released, waiting for synchronized lock
// SETTLE    | lock must stay high SETTLE_CYCLES in a row
// CLEAR     | one-cycle clear pulse to the counters
// MEASURE   | counter enable window, GATE_CYCLES wide
// DONE      | counts frozen and valid
// FAIL      | lock timeout or lock lost; error latched
module pll_seq_ctrl #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 1_000_000,
    parameter int unsigned SETTLE_CYCLES = 1000,
    parameter int unsigned GATE_CYCLES   = 100_000_000
) (
    input  logic       clk_100MHz_i,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       pwrdwn_req_i,
    input  logic       lock_i,
    output logic       pll_rst_o,
    output logic       pll_pwrdwn_o,
    output logic       cnt_clr_o,
    output logic       cnt_en_o,
    output logic       done_o,
    output logic [1:0] err_o,
    output logic [3:0] state_o
);

    localparam int unsigned SEQ_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int SEQ_W  = (SEQ_MAX > 1)      ? $clog2(SEQ_MAX)      : 1;
    localparam int TMO_W  = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int GATE_W = (GATE_CYCLES > 1)  ? $clog2(GATE_CYCLES)  : 1;

    localparam logic [SEQ_W-1:0]  RST_LOAD    = SEQ_W'(RST_CYCLES - 1);
    localparam logic [SEQ_W-1:0]  SETTLE_LOAD = SEQ_W'(SETTLE_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LOAD    = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [GATE_W-1:0] GATE_LOAD   = GATE_W'(GATE_CYCLES - 1);

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_TMO  = 2'b01;
    localparam logic [1:0] ERR_LOST = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_PWRDN     = 4'd1,
        S_RST_HOLD  = 4'd2,
        S_WAIT_LOCK = 4'd3,
        S_SETTLE    = 4'd4,
        S_CLEAR     = 4'd5,
        S_MEASURE   = 4'd6,
        S_DONE      = 4'd7,
        S_FAIL      = 4'd8
    } state_e;

    state_e             state_q, state_d;
    logic               lock_meta_q, lock_s_q;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [GATE_W-1:0]  gate_q, gate_d;
    logic [1:0]         err_q, err_d;
    logic               pll_rst_q, pll_rst_d;
    logic               pwrdwn_q, pwrdwn_d;
    logic               clr_q, clr_d;
    logic               en_q, en_d;
    logic               done_q, done_d;

    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        tmo_d   = tmo_q;
        gate_d  = gate_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start_i) begin
                    state_d = S_RST_HOLD;
                    seq_d   = RST_LOAD;
                    tmo_d   = TMO_LOAD;
                    err_d   = ERR_NONE;
                end
            end
            S_RST_HOLD: begin
                if (seq_q == '0) begin
                    state_d = S_WAIT_LOCK;
                end else begin
                    seq_d = seq_q - SEQ_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (tmo_q == '0) begin
                    state_d = S_FAIL;
                    err_d   = ERR_TMO;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                    if (lock_s_q) begin
                        state_d = S_SETTLE;
                        seq_d   = SETTLE_LOAD;
                    end
                end
            end
            S_SETTLE: begin
                // The timeout budget spans WAIT_LOCK and SETTLE together, so a
                // lock that keeps glitching still ends in FAIL.
                if (tmo_q == '0) begin
                    state_d = S_FAIL;
                    err_d   = ERR_TMO;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                    if (!lock_s_q) begin
                        state_d = S_WAIT_LOCK;
                    end else if (seq_q == '0) begin
                        state_d = S_CLEAR;
                    end else begin
                        seq_d = seq_q - SEQ_W'(1);
                    end
                end
            end
            S_CLEAR: begin
                state_d = S_MEASURE;
                gate_d  = GATE_LOAD;
            end
            S_MEASURE: begin
                if (!lock_s_q) begin
                    state_d = S_FAIL;
                    err_d   = ERR_LOST;
                end else if (gate_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    gate_d = gate_q - GATE_W'(1);
                end
            end
            S_PWRDN: begin
                if (!pwrdwn_req_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (pwrdwn_req_i) begin
            state_d = S_PWRDN;
            err_d   = err_q;
        end
    end

    // Outputs decode the next state so they register alongside it.
    always_comb begin
        pll_rst_d = state_d inside {S_IDLE, S_PWRDN, S_RST_HOLD, S_FAIL};
        pwrdwn_d  = (state_d == S_PWRDN);
        clr_d     = (state_d == S_CLEAR);
        en_d      = (state_d == S_MEASURE);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk_100MHz_i) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            seq_q       <= '0;
            tmo_q       <= '0;
            gate_q      <= '0;
            err_q       <= ERR_NONE;
            pll_rst_q   <= 1'b1;
            pwrdwn_q    <= 1'b0;
            clr_q       <= 1'b0;
            en_q        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_meta_q <= lock_i;
            lock_s_q    <= lock_meta_q;
            seq_q       <= seq_d;
            tmo_q       <= tmo_d;
            gate_q      <= gate_d;
            err_q       <= err_d;
            pll_rst_q   <= pll_rst_d;
            pwrdwn_q    <= pwrdwn_d;
            clr_q       <= clr_d;
            en_q        <= en_d;
            done_q      <= done_d;
        end
    end

    assign pll_rst_o    = pll_rst_q;
    assign pll_pwrdwn_o = pwrdwn_q;
    assign cnt_clr_o    = clr_q;
    assign cnt_en_o     = en_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Directed bench for pll_seq_ctrl with small parameters; lock_i is driven by a
// tick-indexed lock model relative to WAIT_LOCK entry.
module tb_pll_seq_ctrl;

    logic       clk_100MHz_i = 1'b0;
    logic       rst_n        = 1'b0;
    logic       start_i      = 1'b0;
    logic       pwrdwn_req_i = 1'b0;
    logic       lock_i       = 1'b0;
    logic       pll_rst_o;
    logic       pll_pwrdwn_o;
    logic       cnt_clr_o;
    logic       cnt_en_o;
    logic       done_o;
    logic [1:0] err_o;
    logic [3:0] state_o;

    int checks   = 0;
    int failures = 0;

    int end_t, first_settle, n_settle, n_entries, n_clr, n_en;
    int clr_then_en, en_then_done;

    pll_seq_ctrl #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (40),
        .SETTLE_CYCLES(8),
        .GATE_CYCLES  (16)
    ) dut (
        .clk_100MHz_i(clk_100MHz_i),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .pwrdwn_req_i(pwrdwn_req_i),
        .lock_i      (lock_i),
        .pll_rst_o   (pll_rst_o),
        .pll_pwrdwn_o(pll_pwrdwn_o),
        .cnt_clr_o   (cnt_clr_o),
        .cnt_en_o    (cnt_en_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .state_o     (state_o)
    );

    always #5 clk_100MHz_i = ~clk_100MHz_i;

    task automatic tick();
        @(posedge clk_100MHz_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"},   32'(state_o),      32'd0);
        check({tag, "_pll_rst"}, 32'(pll_rst_o),    32'd1);
        check({tag, "_pwrdwn"},  32'(pll_pwrdwn_o), 32'd0);
        check({tag, "_clr"},     32'(cnt_clr_o),    32'd0);
        check({tag, "_en"},      32'(cnt_en_o),     32'd0);
        check({tag, "_done"},    32'(done_o),       32'd0);
        check({tag, "_err"},     32'(err_o),        32'd0);
    endtask

    // Start pulse, RST_HOLD for 4 cycles, ends on the WAIT_LOCK entry sample (t=0).
    task automatic start_seq(input string tag);
        lock_i  = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check({tag, "_hold_state"}, 32'(state_o),   32'd2);
        check({tag, "_hold_err"},   32'(err_o),     32'd0);
        check({tag, "_hold_done"},  32'(done_o),    32'd0);
        check({tag, "_hold_rst"},   32'(pll_rst_o), 32'd1);
        repeat (3) tick();
        check({tag, "_hold_last"},  32'(pll_rst_o), 32'd1);
        tick();
        check({tag, "_wait_state"}, 32'(state_o),   32'd3);
        check({tag, "_wait_rst"},   32'(pll_rst_o), 32'd0);
    endtask

    // Runs from WAIT_LOCK entry; lock_i changes after sample t equal to lock_t,
    // drop_t, restore_t. Ends on done, FAIL, sample stop_t, or the tick budget.
    task automatic run_seq(input int lock_t, input int drop_t, input int restore_t, input int stop_t);
        logic       prev_clr = 1'b0;
        logic       prev_en  = 1'b0;
        logic [3:0] prev_st  = 4'd3;
        end_t = -1; first_settle = -1;
        n_settle = 0; n_entries = 0; n_clr = 0; n_en = 0;
        clr_then_en = 0; en_then_done = 0;
        for (int t = 1; t <= 150; t++) begin
            tick();
            if (state_o == 4'd4) begin
                n_settle++;
                if (prev_st != 4'd4) n_entries++;
                if (first_settle < 0) first_settle = t;
            end
            if (cnt_clr_o) n_clr++;
            if (cnt_en_o) begin
                if (n_en == 0 && prev_clr) clr_then_en = 1;
                n_en++;
            end
            if (done_o && prev_en && !cnt_en_o) en_then_done = 1;
            prev_clr = cnt_clr_o;
            prev_en  = cnt_en_o;
            prev_st  = state_o;
            if (done_o || state_o == 4'd8 || t == stop_t) begin
                end_t = t;
                break;
            end
            if (t == lock_t)    lock_i = 1'b1;
            if (t == drop_t)    lock_i = 1'b0;
            if (t == restore_t) lock_i = 1'b1;
        end
    endtask

    task automatic check_nominal(input string tag);
        check({tag, "_end_t"},        32'(end_t),        32'd37);
        check({tag, "_first_settle"}, 32'(first_settle), 32'd12);
        check({tag, "_settle_len"},   32'(n_settle),     32'd8);
        check({tag, "_clr_pulses"},   32'(n_clr),        32'd1);
        check({tag, "_en_width"},     32'(n_en),         32'd16);
        check({tag, "_clr_then_en"},  32'(clr_then_en),  32'd1);
        check({tag, "_en_then_done"}, 32'(en_then_done), 32'd1);
        check({tag, "_done"},         32'(done_o),       32'd1);
        check({tag, "_state"},        32'(state_o),      32'd7);
        check({tag, "_err"},          32'(err_o),        32'd0);
    endtask

    initial begin
        // Reset
        repeat (2) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();
        check("idle_hold_state", 32'(state_o), 32'd0);

        // Nominal: lock rises 10 cycles after pll_rst falls
        start_seq("nom");
        run_seq(9, -1, -1, 0);
        check_nominal("nom");

        // Never locks: FAIL 40 cycles after WAIT_LOCK entry
        start_seq("nolock");
        run_seq(-1, -1, -1, 0);
        check("nolock_end_t",   32'(end_t),     32'd40);
        check("nolock_state",   32'(state_o),   32'd8);
        check("nolock_err",     32'(err_o),     32'd1);
        check("nolock_pll_rst", 32'(pll_rst_o), 32'd1);
        check("nolock_en",      32'(cnt_en_o),  32'd0);

        // Glitch at settle count 5: 3 low cycles, back to WAIT_LOCK, full resettle
        start_seq("glitch");
        run_seq(9, 16, 19, 0);
        check("glitch_end_t",      32'(end_t),     32'd47);
        check("glitch_settle_cyc", 32'(n_settle),  32'd15);
        check("glitch_entries",    32'(n_entries), 32'd2);
        check("glitch_en_width",   32'(n_en),      32'd16);
        check("glitch_done",       32'(done_o),    32'd1);
        check("glitch_err",        32'(err_o),     32'd0);

        // Lock lost after 6 enable cycles: two sync cycles later the window closes
        start_seq("lost");
        run_seq(9, 26, -1, 0);
        check("lost_end_t",   32'(end_t),     32'd29);
        check("lost_en",      32'(n_en),      32'd8);
        check("lost_state",   32'(state_o),   32'd8);
        check("lost_err",     32'(err_o),     32'd2);
        check("lost_done",    32'(done_o),    32'd0);
        check("lost_pll_rst", 32'(pll_rst_o), 32'd1);

        // Power-down mid-MEASURE (start_seq also confirms err cleared by start)
        start_seq("pwr");
        run_seq(9, -1, -1, 24);
        check("pwr_pre_state", 32'(state_o),  32'd6);
        check("pwr_pre_en",    32'(cnt_en_o), 32'd1);
        check("pwr_pre_width", 32'(n_en),     32'd4);
        pwrdwn_req_i = 1'b1;
        tick();
        check("pwr_state",   32'(state_o),      32'd1);
        check("pwr_pwrdwn",  32'(pll_pwrdwn_o), 32'd1);
        check("pwr_en",      32'(cnt_en_o),     32'd0);
        check("pwr_done",    32'(done_o),       32'd0);
        check("pwr_pll_rst", 32'(pll_rst_o),    32'd1);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("pwr_prio_state", 32'(state_o), 32'd1);
        pwrdwn_req_i = 1'b0;
        tick();
        check("pwr_rel_state",  32'(state_o),      32'd0);
        check("pwr_rel_pwrdwn", 32'(pll_pwrdwn_o), 32'd0);

        // Reset mid-SETTLE, then an exact nominal replay
        start_seq("rst");
        run_seq(9, -1, -1, 16);
        check("rst_pre_state", 32'(state_o), 32'd4);
        rst_n  = 1'b0;
        lock_i = 1'b0;
        tick();
        check_reset_outputs("rst_mid");
        rst_n = 1'b1;
        tick();
        check("rst_idle_state", 32'(state_o), 32'd0);
        start_seq("replay");
        run_seq(9, -1, -1, 0);
        check_nominal("replay");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
